// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU sequencer.
// Contents: default data/opcode widths, timeout length, ALU opcode
// encodings, the sequencer state encoding, and an opcode-legality helper.
package uart_pkg;

  localparam int DEF_NB_DATA       = 8;
  localparam int DEF_NB_OP         = 6;
  localparam int DEF_TIMEOUT_TICKS = 704;  // 4 byte-times at 16 ticks/bit

  localparam logic [DEF_NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [DEF_NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [DEF_NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [DEF_NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [DEF_NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [DEF_NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [DEF_NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [DEF_NB_OP-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // True when the low opcode bits name an operation the ALU implements.
  function automatic logic op_known(input logic [DEF_NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_byte_timeout.sv
// Inter-byte timeout counter, counted in baud ticks.
// Ports:
//   i_clock  - system clock
//   i_reset  - async active-low reset
//   i_clear  - synchronous clear (wins over i_enable)
//   i_enable - count one tick this cycle
//   o_expire - combinational: this enabled tick is the last one allowed
module byte_timeout #(
  parameter int TICKS = 704
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int W = $clog2(TICKS);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt;

  assign o_expire = i_enable && (cnt == LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)       cnt <= '0;
    else if (i_clear)   cnt <= '0;
    else if (i_enable)  cnt <= o_expire ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART RX, UART TX and a combinational ALU.
// Collects operand A, operand B and opcode bytes, validates the opcode,
// latches the ALU result and launches one TX transmission of it.
// Ports:
//   i_clock, i_reset (async active-low)
//   i_tick                 baud tick
//   i_rx_done, i_rx_data   receiver byte strobe (level) and data
//   i_tx_done              transmitter completion (level)
//   i_alu_result           ALU output for o_alu_a/b/op
//   o_alu_a/b/op           registered ALU operands/opcode
//   o_tx_start, o_tx_data  transmitter launch and byte
//   o_error                one-cycle pulse: timeout, bad opcode, dropped byte
//   o_busy                 frame in progress (state != WAIT_A)
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int NB_DATA       = DEF_NB_DATA,
  parameter int NB_OP         = DEF_NB_OP,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_error,
  output logic               o_busy
);

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t state, state_nxt;
  logic   rx_prev, tx_prev;
  logic   rx_acc, tx_edge, in_wait, tmo_expire, op_ok, err_nxt;

  // Done strobes may stay high for many cycles; only the rising edge counts.
  assign rx_acc  = i_rx_done & ~rx_prev;
  assign tx_edge = i_tx_done & ~tx_prev;
  assign in_wait = (state == WAIT_B) || (state == WAIT_OP);
  assign op_ok   = ~|i_rx_data[NB_DATA-1:NB_OP] && op_known(i_rx_data[NB_OP-1:0]);

  // Counter is held clear outside the timed states, so entering WAIT_B or
  // WAIT_OP always starts from zero; every accepted byte restarts it too.
  byte_timeout #(.TICKS(TIMEOUT_TICKS)) u_tmo (
    .i_clock  (i_clock),
    .i_reset  (rst_n),
    .i_clear  (rx_acc | ~in_wait),
    .i_enable (i_tick & in_wait),
    .o_expire (tmo_expire)
  );

  // Accept is checked before expiry so a byte landing on the last tick wins.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      WAIT_A:  if (rx_acc) state_nxt = WAIT_B;
      WAIT_B: begin
        if (rx_acc) state_nxt = WAIT_OP;
        else if (tmo_expire) begin
          state_nxt = WAIT_A;
          err_nxt   = 1'b1;
        end
      end
      WAIT_OP: begin
        if (rx_acc) begin
          if (op_ok) state_nxt = COMPUTE;
          else begin
            state_nxt = WAIT_A;
            err_nxt   = 1'b1;
          end
        end else if (tmo_expire) begin
          state_nxt = WAIT_A;
          err_nxt   = 1'b1;
        end
      end
      COMPUTE: begin
        state_nxt = SEND;
        err_nxt   = rx_acc;
      end
      SEND: begin
        if (i_tick) state_nxt = WAIT_TX;
        err_nxt = rx_acc;
      end
      WAIT_TX: begin
        if (tx_edge) state_nxt = WAIT_A;
        err_nxt = rx_acc;
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_A;
      rx_prev   <= 1'b0;
      tx_prev   <= 1'b0;
      o_error   <= 1'b0;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      state   <= state_nxt;
      rx_prev <= i_rx_done;
      tx_prev <= i_tx_done;
      o_error <= err_nxt;
      if (rx_acc && state == WAIT_A)          o_alu_a   <= i_rx_data;
      if (rx_acc && state == WAIT_B)          o_alu_b   <= i_rx_data;
      if (rx_acc && state == WAIT_OP && op_ok) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (state == COMPUTE)                   o_tx_data <= i_alu_result;
    end
  end

  // Decoded from state so reset drops them without waiting for a clock.
  assign o_tx_start = (state == SEND);
  assign o_busy     = (state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;
  import uart_pkg::*;

  logic       i_clock = 1'b0, i_reset = 1'b1, i_tick = 1'b0;
  logic       i_rx_done = 1'b0, i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00, i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_error, o_busy;

  int errors = 0, checks = 0, cyc = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [5:0] op;
    int         cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  uart_alu_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_tx_done(i_tx_done),
    .i_alu_result(i_alu_result), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_error(o_error), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  // ALU peripheral model
  always_comb begin
    case (o_alu_op)
      OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
      OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
      OP_AND:  i_alu_result = o_alu_a & o_alu_b;
      OP_OR:   i_alu_result = o_alu_a | o_alu_b;
      OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
      OP_NOR:  i_alu_result = ~(o_alu_a | o_alu_b);
      default: i_alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // baud tick every 4 clocks
  initial begin
    int d;
    d = 0;
    forever begin
      @(posedge i_clock); #1;
      i_tick = (d == 3);
      d = (d + 1) % 4;
    end
  end

  // UART_TX model: completes 40 cycles after the start strobe drops
  initial forever begin
    @(negedge i_clock);
    if (o_tx_start) begin
      while (o_tx_start) @(negedge i_clock);
      repeat (40) @(negedge i_clock);
      i_tx_done = 1'b1;
      repeat (3) @(negedge i_clock);
      i_tx_done = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever a TX launch or an error appears.
  logic st_prev = 1'b0, er_prev = 1'b0;
  always @(negedge i_clock) begin
    if (!i_reset) begin
      st_prev = 1'b0;
      er_prev = 1'b0;
    end else begin
      if (o_tx_start && !st_prev) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got data %0h expected no launch", o_tx_data);
        end else begin
          mon_e = sbq.pop_front();
          chk("tx_kind_is_err", 64'(o_error), 64'(mon_e.is_err));
          chk("tx_data", 64'(o_tx_data), 64'(mon_e.data));
          chk("tx_op", 64'(o_alu_op), 64'(mon_e.op));
          chk("tx_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      if (o_error) begin
        chk("err_single_cycle", 64'(er_prev), 64'd0);
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected: got o_error=1 expected 0 at cycle %0d", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("err_kind", 64'(mon_e.is_err), 64'd1);
        end
      end
      st_prev = o_tx_start;
      er_prev = o_error;
    end
  end

  task automatic byte_on(input logic [7:0] d, output int k);
    @(posedge i_clock); #1;
    k = cyc;
    i_rx_data = d;
    i_rx_done = 1'b1;
  endtask

  task automatic byte_off(input int hold);
    repeat (hold) begin @(posedge i_clock); #1; end
    i_rx_done = 1'b0;
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1; x.data = 8'h00; x.op = 6'h00; x.cyc = 0;
    sbq.push_back(x);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input int hold, input logic [7:0] res, input bit ok);
    int   k;
    exp_t x;
    byte_on(a, k); byte_off(hold);
    byte_on(b, k); byte_off(hold);
    if (!ok) push_err();
    byte_on(op, k);
    if (ok) begin
      x.is_err = 1'b0; x.data = res; x.op = op[5:0]; x.cyc = k + 2;
      sbq.push_back(x);
    end
    byte_off(hold);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge i_clock); n++; end while (o_busy && n < 2000);
    chk(name, 64'(o_busy), 64'd0);
  endtask

  task automatic wait_start(input logic lvl);
    int n;
    n = 0;
    while (o_tx_start !== lvl && n < 200) begin @(negedge i_clock); n++; end
    chk("tx_start_wait", 64'(o_tx_start), 64'(lvl));
  endtask

  initial begin
    int k, n;
    #2 i_reset = 1'b0;
    repeat (3) @(posedge i_clock); #1;
    chk("reset_outputs", {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_error, o_busy}, 64'd0);
    i_reset = 1'b1;
    repeat (4) @(posedge i_clock);

    // ADD 5+3
    frame(8'h05, 8'h03, 8'h20, 1, 8'h08, 1'b1);
    wait_idle("add_back_to_idle");
    chk("add_op", 64'(o_alu_op), 64'h20);

    // AND with long rx_done levels
    frame(8'hAA, 8'h0F, 8'h24, 50, 8'h0A, 1'b1);
    wait_idle("and_back_to_idle");
    chk("and_a", 64'(o_alu_a), 64'hAA);
    chk("and_b", 64'(o_alu_b), 64'h0F);

    // invalid opcode
    frame(8'h01, 8'h02, 8'h3F, 1, 8'h00, 1'b0);
    @(negedge i_clock);
    chk("badop_idle", 64'(o_busy), 64'd0);
    chk("badop_op_kept", 64'(o_alu_op), 64'h24);
    chk("badop_a_loaded", 64'(o_alu_a), 64'h01);

    // timeout after one byte
    push_err();
    byte_on(8'h01, k); byte_off(1);
    n = 0; k = 0;
    while (n < 703 && k < 4000) begin @(negedge i_clock); k++; if (i_tick) n++; end
    @(posedge i_clock); #1;
    chk("tmo_busy_before_last_tick", 64'(o_busy), 64'd1);
    while (n < 704 && k < 4000) begin @(negedge i_clock); k++; if (i_tick) n++; end
    @(posedge i_clock); #1;
    chk("tmo_busy_after_last_tick", 64'(o_busy), 64'd0);
    frame(8'h09, 8'h04, 8'h22, 1, 8'h05, 1'b1);
    wait_idle("sub_back_to_idle");

    // extra byte during WAIT_TX
    frame(8'h0F, 8'hF0, 8'h25, 1, 8'hFF, 1'b1);
    wait_start(1'b1);
    wait_start(1'b0);
    push_err();
    byte_on(8'h55, k); byte_off(2);
    wait_idle("extra_byte_tx_completes");
    chk("extra_byte_tx_data", 64'(o_tx_data), 64'hFF);
    chk("extra_byte_a_kept", 64'(o_alu_a), 64'h0F);

    // reset while waiting for the opcode
    byte_on(8'h11, k); byte_off(1);
    byte_on(8'h22, k); byte_off(1);
    @(negedge i_clock); #2;
    i_reset = 1'b0;
    #1;
    chk("midframe_reset_outputs", {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_error, o_busy}, 64'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    repeat (4) @(posedge i_clock);
    frame(8'h0C, 8'h0A, 8'h26, 1, 8'h06, 1'b1);
    wait_idle("xor_back_to_idle");

    repeat (5) @(negedge i_clock);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencer between UART_RX, UART_TX and the combinational ALU. Collects three bytes from the receiver (operand A, operand B, opcode), validates the opcode and drives it onto the ALU. It then launches one transmission of the 8-bit result through the transmitter. It also enforces an inter-byte timeout counted in baud ticks from BR_GENERATOR and flags protocol errors.

## Interface
- NB_DATA, 8, operand/result width
- NB_OP, 6, opcode width (low bits of third byte)
- TIMEOUT_TICKS, 704, baud ticks allowed between bytes of one frame (4 byte-times at 16 ticks/bit)
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_tick  in  1  baud tick from BR_GENERATOR, one-cycle pulse
- i_rx_done  in  1  UART_RX o_done_bit; may stay high several cycles
- i_rx_data  in  NB_DATA  UART_RX o_data_byte, valid while i_rx_done high
- i_tx_done  in  1  UART_TX o_done_bit
- i_alu_result  in  NB_DATA  ALU result for current o_alu_a/b/op
- o_alu_a  out  NB_DATA  registered operand A
- o_alu_b  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- o_tx_start  out  1  to UART_TX i_tx_signal
- o_tx_data  out  NB_DATA  to UART_TX i_data_byte, registered result
- o_error  out  1  one-cycle pulse on timeout, bad opcode or dropped byte
- o_busy  out  1  high in every state except WAIT_A

## Operation
- Byte accept = rising edge of i_rx_done (i_rx_done=1, registered previous=0). Level high for many cycles counts once.
- States: WAIT_A -> WAIT_B -> WAIT_OP -> COMPUTE -> SEND -> WAIT_TX -> WAIT_A.
- WAIT_A: on accept, load o_alu_a, go WAIT_B. No timeout.
- WAIT_B: on accept, load o_alu_b, go WAIT_OP.
- WAIT_OP: on accept, check byte. Valid: bits[7:6]=0 and low 6 bits in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010}. Valid -> load o_alu_op, go COMPUTE. Invalid -> o_error pulse, o_alu_op unchanged, go WAIT_A.
- Timeout: counter cleared on entering WAIT_B/WAIT_OP and on every accept. Increments on i_tick in those states. On i_tick with count = TIMEOUT_TICKS-1: o_error pulse, go WAIT_A, counter cleared.
- COMPUTE: one cycle; o_tx_data <= i_alu_result; go SEND.
- SEND: o_tx_start=1. Stays in SEND until the first i_tick observed in SEND; on that tick go WAIT_TX, o_tx_start=0 next cycle.
- WAIT_TX: on rising edge of i_tx_done go WAIT_A. No timeout.
- Accept in COMPUTE/SEND/WAIT_TX: byte dropped, o_error pulse, state unaffected.
- Operands/opcode persist until overwritten. ALU output stays valid between frames.

## Timing
- Reset (async assert, sync-safe deassert internal): state WAIT_A, o_alu_a/b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0, o_error=0, o_busy=0, counters/edge regs 0.
- Accept detected in cycle t -> register loaded and state changed visible at t+1.
- Opcode accept at t: COMPUTE at t+1, o_tx_data valid and o_tx_start=1 from t+2.
- o_error is registered, high exactly one cycle, asserted cycle after cause.
- Accept and timeout tick in same cycle: accept wins, counter cleared, no error.
- Reset mid-frame: immediate return to WAIT_A; partial operands discarded (cleared to 0); o_tx_start drops asynchronously.

## Structure
- Shared package uart_pkg: NB_DATA/NB_OP defaults, opcode localparams (OP_ADD ... OP_SRL), state encoding localparams, TIMEOUT_TICKS default.
- One sub-module: byte_timeout (tick counter with clear/enable, expiry flag, width $clog2(TIMEOUT_TICKS)).
- Edge detectors for i_rx_done/i_tx_done inline.

## Test plan
- Frame 0x05, 0x03, 0x20 (ADD) -> o_alu_op=100000; o_tx_start high from cycle opcode_accept+2; o_tx_data=0x08 (with ALU model); back to WAIT_A after i_tx_done; o_error never high.
- Frame 0xAA, 0x0F, 0x24 (AND) with i_rx_done held high 50 cycles per byte -> each byte counted once, o_tx_data=0x0A.
- Frame 0x01, 0x02, 0x3F (invalid) -> one o_error pulse, no o_tx_start, o_alu_op keeps previous value, state WAIT_A.
- Send 0x01 then nothing for 704 ticks -> o_error pulse on tick 704, o_busy falls; next 3-byte SUB frame 0x09, 0x04, 0x22 gives 0x05.
- Extra byte injected during WAIT_TX -> o_error pulse, transmission completes unchanged.
- Reset asserted in WAIT_OP -> all outputs 0 within the same cycle; subsequent full frame processed normally.
